// File: rtl/sequential_div_8bit_pkg.sv
// sequential_div_8bit_pkg: shared FSM state encodings for the sequential divider
package sequential_div_8bit_pkg;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/div_trial_sub.sv
// div_trial_sub: combinational trial subtractor a-b computed as a+~b+1, borrow is the result MSB
module div_trial_sub #(
    parameter int W = 9
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-2:0] diff,
    output logic         borrow
);
    assign {borrow, diff} = a + ~b + W'(1);
endmodule

// File: rtl/sequential_div_8bit.sv
// sequential_div_8bit: multi-cycle unsigned restoring divider, one quotient bit per clock
module sequential_div_8bit
    import sequential_div_8bit_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t           state, nxt;
    logic [WIDTH-1:0] r, q, d, diff, r_nx, q_nx;
    logic [WIDTH:0]   rs;
    logic [CW-1:0]    count;
    logic             borrow, last, accept, dz_in;

    assign rs     = {r, q[WIDTH-1]};
    assign last   = count == CW'(WIDTH - 1);
    assign accept = state == S_IDLE && start;
    assign dz_in  = divisor == '0;
    assign q_nx   = {q[WIDTH-2:0], ~borrow};
    assign r_nx   = borrow ? rs[WIDTH-1:0] : diff;

    div_trial_sub #(.W(WIDTH + 1)) u_sub (
        .a      (rs),
        .b      ({1'b0, d}),
        .diff   (diff),
        .borrow (borrow)
    );

    // state register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= nxt;
    end

    // next state: a zero divisor skips RUN, unused encodings fall back to IDLE
    always_comb begin
        nxt = S_IDLE;
        nxt = (state == S_IDLE) ? (start ? (dz_in ? S_DONE : S_RUN) : S_IDLE) :
              (state == S_RUN)  ? (last ? S_DONE : S_RUN) : S_IDLE;
    end

    // datapath iteration and registered outputs, results load only on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= nxt == S_RUN;
            done <= nxt == S_DONE;
            if (accept) begin
                q     <= dividend;
                d     <= divisor;
                r     <= '0;
                count <= '0;
                if (dz_in) begin
                    quotient    <= '1;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == S_RUN) begin
                r     <= r_nx;
                q     <= q_nx;
                count <= count + CW'(1);
                if (last) begin
                    quotient    <= q_nx;
                    remainder   <= r_nx;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sequential_div_8bit.sv
// tb_sequential_div_8bit: directed and randomised checks of the sequential divider
module tb_sequential_div_8bit;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       busy, done, div_by_zero;
    logic [7:0] quotient, remainder;
    int         n_checks = 0;
    int         n_fail = 0;

    sequential_div_8bit #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // issue one start, optionally re-pulse start (9/2) in busy cycle inj, return at the done cycle
    task automatic run(input logic [7:0] a, input logic [7:0] b, input int inj,
                       output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = ~a; divisor = ~b;
        lat = 0; nbusy = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (busy) nbusy++;
            if (done) lat = k;
            else begin
                if (k == inj) begin start = 1'b1; dividend = 8'd9; divisor = 8'd2; end
                @(negedge clk);
                start = 1'b0;
            end
        end
    endtask

    typedef struct { logic [7:0] a, b, q, r; } vec_t;
    vec_t vecs[3] = '{'{8'd255, 8'd1, 8'd255, 8'd0},
                      '{8'd5, 8'd9, 8'd0, 8'd5},
                      '{8'd200, 8'd200, 8'd1, 8'd0}};

    initial begin
        int lat, nb;
        logic saw;
        logic [7:0] a, b;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_q", quotient, 0);
        check("rst_r", remainder, 0);
        check("rst_dz", div_by_zero, 0);

        run(8'd100, 8'd7, 0, lat, nb);
        check("t1_lat", lat, 9);
        check("t1_busy", nb, 8);
        check("t1_q", quotient, 14);
        check("t1_r", remainder, 2);
        check("t1_dz", div_by_zero, 0);
        @(negedge clk);
        check("t1_pulse", done, 0);

        foreach (vecs[i]) begin
            run(vecs[i].a, vecs[i].b, 0, lat, nb);
            check("t2_lat", lat, 9);
            check("t2_q", quotient, vecs[i].q);
            check("t2_r", remainder, vecs[i].r);
        end

        run(8'd37, 8'd0, 0, lat, nb);
        check("t3_lat", lat, 1);
        check("t3_busy", nb, 0);
        check("t3_q", quotient, 8'hFF);
        check("t3_r", remainder, 37);
        check("t3_dz", div_by_zero, 1);

        @(negedge clk);
        start = 1'b1; dividend = 8'd100; divisor = 8'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_busy_pre", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t4_busy", busy, 0);
        check("t4_q", quotient, 0);
        check("t4_r", remainder, 0);
        check("t4_dz", div_by_zero, 0);
        saw = 1'b0;
        repeat (12) begin @(negedge clk); if (done || busy) saw = 1'b1; end
        check("t4_nodone", saw, 0);
        run(8'd50, 8'd3, 0, lat, nb);
        check("t4_lat", lat, 9);
        check("t4_q2", quotient, 16);
        check("t4_r2", remainder, 2);

        run(8'd100, 8'd7, 3, lat, nb);
        check("t5_lat", lat, 9);
        check("t5_q", quotient, 14);
        check("t5_r", remainder, 2);
        run(8'd9, 8'd2, 0, lat, nb);
        check("t5_b2b_lat", lat, 9);
        check("t5_b2b_q", quotient, 4);
        check("t5_b2b_r", remainder, 1);

        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run(a, b, 0, lat, nb);
            if (b != 0) begin
                check("t6_lat", lat, 9);
                check("t6_inv", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                check("t6_rlt", remainder < b, 1);
                check("t6_q", quotient, a / b);
                check("t6_dz", div_by_zero, 0);
            end else begin
                check("t6_lat0", lat, 1);
                check("t6_q0", quotient, 8'hFF);
                check("t6_r0", remainder, a);
                check("t6_dz0", div_by_zero, 1);
            end
            @(negedge clk);
            check("t6_pulse", done, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
